// File: rtl/morse_char_sequencer.sv
// ---------------------------------------------------------------------------
// morse_char_sequencer
//
// Purpose:
//   Converts ASCII characters, delivered over a valid/ready handshake, into
//   Morse on/off timing on a single LED pin. Owns the unit-time prescaler and
//   the element/gap state machine. Sits between a character source (UART,
//   ROM walker) and the board LED.
//
//   Letters A-Z / a-z (folded to upper case) and digits 0-9 are keyed.
//   Space (0x20) produces 4 units of silence on top of the 3-unit character
//   gap that already followed the previous character, making a 7-unit word
//   gap. Any other code is accepted, produces no output and raises a
//   one-cycle err pulse.
//
// Configuration:
//   MORSE_FIFO_EN  when defined, a 4-entry input FIFO decouples the source
//                  from the keyer (in_ready = !full, one turnaround cycle
//                  between characters). When undefined the block has no
//                  storage and in_ready = (state == IDLE).
//
// Parameters:
//   UNIT_DIV  clocks per Morse unit (>= 2)
//   DIV_W     prescaler width, 2**DIV_W >= UNIT_DIV
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_data   in   [7:0] ASCII character
//   in_valid  in   in_data valid
//   in_ready  out  block accepts in_data this cycle
//   abort     in   synchronous cancel of current character (and queue)
//   led       out  Morse output, 1 = mark (registered)
//   busy      out  high while keying (or queue non-empty), registered
//   err       out  one-cycle pulse: unsupported character dropped
// ---------------------------------------------------------------------------
module morse_char_sequencer #(
   parameter int UNIT_DIV = 2000000,
   parameter int DIV_W    = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic       led,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MARK  = 3'd1,
      EGAP  = 3'd2,
      CGAP  = 3'd3,
      SPACE = 3'd4
   } state_t;

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(UNIT_DIV - 1);
   localparam logic [7:0]       ASCII_SPACE = 8'h20;

   // Encode table: returns {supported, len[2:0], pat[4:0]}.
   // pat is LSB first (bit 0 is the first element), bit value 1 = dash.
   function automatic logic [8:0] encode(input logic [7:0] c);
      logic [7:0] u;
      logic [8:0] r;
      u = c;
      if (c >= 8'h61 && c <= 8'h7A) begin
         u = c - 8'h20;
      end
      case (u)
         8'h41:   r = {1'b1, 3'd2, 5'b00010}; // A .-
         8'h42:   r = {1'b1, 3'd4, 5'b00001}; // B -...
         8'h43:   r = {1'b1, 3'd4, 5'b00101}; // C -.-.
         8'h44:   r = {1'b1, 3'd3, 5'b00001}; // D -..
         8'h45:   r = {1'b1, 3'd1, 5'b00000}; // E .
         8'h46:   r = {1'b1, 3'd4, 5'b00100}; // F ..-.
         8'h47:   r = {1'b1, 3'd3, 5'b00011}; // G --.
         8'h48:   r = {1'b1, 3'd4, 5'b00000}; // H ....
         8'h49:   r = {1'b1, 3'd2, 5'b00000}; // I ..
         8'h4A:   r = {1'b1, 3'd4, 5'b01110}; // J .---
         8'h4B:   r = {1'b1, 3'd3, 5'b00101}; // K -.-
         8'h4C:   r = {1'b1, 3'd4, 5'b00010}; // L .-..
         8'h4D:   r = {1'b1, 3'd2, 5'b00011}; // M --
         8'h4E:   r = {1'b1, 3'd2, 5'b00001}; // N -.
         8'h4F:   r = {1'b1, 3'd3, 5'b00111}; // O ---
         8'h50:   r = {1'b1, 3'd4, 5'b00110}; // P .--.
         8'h51:   r = {1'b1, 3'd4, 5'b01011}; // Q --.-
         8'h52:   r = {1'b1, 3'd3, 5'b00010}; // R .-.
         8'h53:   r = {1'b1, 3'd3, 5'b00000}; // S ...
         8'h54:   r = {1'b1, 3'd1, 5'b00001}; // T -
         8'h55:   r = {1'b1, 3'd3, 5'b00100}; // U ..-
         8'h56:   r = {1'b1, 3'd4, 5'b01000}; // V ...-
         8'h57:   r = {1'b1, 3'd3, 5'b00110}; // W .--
         8'h58:   r = {1'b1, 3'd4, 5'b01001}; // X -..-
         8'h59:   r = {1'b1, 3'd4, 5'b01101}; // Y -.--
         8'h5A:   r = {1'b1, 3'd4, 5'b00011}; // Z --..
         8'h30:   r = {1'b1, 3'd5, 5'b11111}; // 0 -----
         8'h31:   r = {1'b1, 3'd5, 5'b11110}; // 1 .----
         8'h32:   r = {1'b1, 3'd5, 5'b11100}; // 2 ..---
         8'h33:   r = {1'b1, 3'd5, 5'b11000}; // 3 ...--
         8'h34:   r = {1'b1, 3'd5, 5'b10000}; // 4 ....-
         8'h35:   r = {1'b1, 3'd5, 5'b00000}; // 5 .....
         8'h36:   r = {1'b1, 3'd5, 5'b00001}; // 6 -....
         8'h37:   r = {1'b1, 3'd5, 5'b00011}; // 7 --...
         8'h38:   r = {1'b1, 3'd5, 5'b00111}; // 8 ---..
         8'h39:   r = {1'b1, 3'd5, 5'b01111}; // 9 ----.
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   state_t           state;
   state_t           next_state;
   logic [1:0]       unit_cnt;
   logic [DIV_W-1:0] presc;
   logic             tick;
   logic [4:0]       pat_reg;
   logic [2:0]       len_reg;

   logic [7:0]       src_char;
   logic             take;
   logic [8:0]       code;
   logic             code_ok;
   logic [2:0]       code_len;
   logic [4:0]       code_pat;
   logic             is_space;
   logic [1:0]       mark_last;

   logic             load_char;
   logic             shift_elem;
   logic             err_next;
   logic             busy_next;

`ifdef MORSE_FIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fifo_count;
   logic [2:0] fifo_count_next;
   logic       push;
   logic       pop;

   // The keyer pulls from the queue head whenever it is idle; abort wins
   // over both push and pop so nothing sneaks in on the flush cycle.
   assign in_ready  = (fifo_count != 3'd4);
   assign push      = in_valid && in_ready && !abort;
   assign pop       = (state == IDLE) && (fifo_count != 3'd0) && !abort;
   assign take      = pop;
   assign src_char  = fifo_mem[rd_ptr];
   assign busy_next = (next_state != IDLE) || (fifo_count_next != 3'd0);

   // Occupancy after this cycle's push/pop, or empty on abort.
   always_comb begin
      fifo_count_next = fifo_count;
      if (abort) begin
         fifo_count_next = 3'd0;
      end else begin
         case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 3'd1;
            2'b01:   fifo_count_next = fifo_count - 3'd1;
            default: fifo_count_next = fifo_count;
         endcase
      end
   end

   // Storage array is write-only from the push side and needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
      end else begin
         fifo_count <= fifo_count_next;
         if (abort) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 2'd1;
            end
         end
      end
   end
`else
   assign in_ready  = (state == IDLE);
   assign take      = in_valid && in_ready && !abort;
   assign src_char  = in_data;
   assign busy_next = (next_state != IDLE);
`endif

   assign code      = encode(src_char);
   assign code_ok   = code[8];
   assign code_len  = code[7:5];
   assign code_pat  = code[4:0];
   assign is_space  = (src_char == ASCII_SPACE);

   // Prescaler is held at zero in IDLE, so the first unit after leaving
   // IDLE is always a full UNIT_DIV clocks.
   assign tick      = (state != IDLE) && (presc == DIV_LAST);

   // A dot ends on the first unit tick, a dash on the third.
   assign mark_last = pat_reg[0] ? 2'd2 : 2'd0;

   // Next-state logic. Element bookkeeping (load/shift) is requested here
   // and carried out in the register block.
   always_comb begin
      next_state = state;
      load_char  = 1'b0;
      shift_elem = 1'b0;
      err_next   = 1'b0;
      if (abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  if (is_space) begin
                     next_state = SPACE;
                  end else if (code_ok) begin
                     next_state = MARK;
                     load_char  = 1'b1;
                  end else begin
                     err_next = 1'b1;
                  end
               end
            end
            MARK: begin
               if (tick && (unit_cnt == mark_last)) begin
                  if (len_reg > 3'd1) begin
                     next_state = EGAP;
                     shift_elem = 1'b1;
                  end else begin
                     next_state = CGAP;
                  end
               end
            end
            EGAP: begin
               if (tick) begin
                  next_state = MARK;
               end
            end
            CGAP: begin
               if (tick && (unit_cnt == 2'd2)) begin
                  next_state = IDLE;
               end
            end
            SPACE: begin
               if (tick && (unit_cnt == 2'd3)) begin
                  next_state = IDLE;
               end
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // State, timing counters, element shifter and registered outputs.
   // led and busy are taken from next_state so they change in the same
   // cycle as the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         unit_cnt <= 2'd0;
         presc    <= '0;
         pat_reg  <= 5'd0;
         len_reg  <= 3'd0;
         led      <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= next_state;

         if (next_state != state) begin
            unit_cnt <= 2'd0;
         end else if (tick) begin
            unit_cnt <= unit_cnt + 2'd1;
         end

         if (abort || (state == IDLE) || (presc == DIV_LAST)) begin
            presc <= '0;
         end else begin
            presc <= presc + DIV_W'(1);
         end

         if (load_char) begin
            pat_reg <= code_pat;
            len_reg <= code_len;
         end else if (shift_elem) begin
            pat_reg <= {1'b0, pat_reg[4:1]};
            len_reg <= len_reg - 3'd1;
         end

         led  <= (next_state == MARK);
         busy <= busy_next;
         err  <= err_next;
      end
   end

endmodule
